// File: rtl/ddc_frame_packer.sv
// Groups N_CH consecutive DDC words into frames, buffers them in a FIFO and
// emits each frame as a 32-bit AXI-Stream packet (one header beat, N_CH*3 data beats).
module ddc_frame_packer #(
  parameter int N_CH    = 4,
  parameter int FIFO_AW = 6
) (
  input  logic        dev_clk,
  input  logic        dev_rst,
  input  logic        resync,
  input  logic [95:0] data_in,
  input  logic        valid_in,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  input  logic        clear_stats,
  output logic [31:0] frame_count,
  output logic [15:0] drop_count
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int POSW  = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef logic [PW-1:0] ptr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  logic [119:0] mem [DEPTH];

  ptr_t            shPtr_q, shPtr_d;
  ptr_t            cmPtr_q, cmPtr_d;
  ptr_t            rdPtr_q, rdPtr_d;
  ptr_t            framesAvail_q, framesAvail_d;
  logic [POSW-1:0] pos_q, pos_d;
  logic            accept_q, accept_d;
  logic [23:0]     seq_q, seq_d;
  logic [31:0]     frameCnt_q, frameCnt_d;
  logic [15:0]     dropCnt_q, dropCnt_d;

  state_t          state_q, state_d;
  logic [1:0]      beat_q, beat_d;
  logic [POSW-1:0] entry_q, entry_d;
  logic [31:0]     tdata_q, tdata_d;
  logic            tvalid_q, tvalid_d;
  logic            tlast_q, tlast_d;

  ptr_t         occupancy;
  ptr_t         freeSlots;
  logic         frameStart;
  logic         lastWord;
  logic         acceptNow;
  logic         commit;
  logic         take;
  logic         wrEn;
  logic         dropEvt;
  logic         handshake;
  logic         popNow;
  logic         launch;
  logic [119:0] curEntry;

  // Space is judged against committed data only; the shadow pointer equals the
  // committed pointer whenever a new frame starts.
  assign occupancy  = cmPtr_q - rdPtr_q;
  assign freeSlots  = PW'(DEPTH) - occupancy;
  assign frameStart = (pos_q == '0);
  assign lastWord   = (pos_q == POSW'(N_CH - 1));
  assign acceptNow  = frameStart ? (freeSlots >= PW'(N_CH)) : accept_q;
  assign commit     = valid_in && acceptNow && lastWord;
  // A resync swallows the coincident word unless that word completes a frame.
  assign take       = valid_in && (!resync || commit);
  assign wrEn       = take && acceptNow;
  assign dropEvt    = take && frameStart && !acceptNow;

  always_comb begin
    shPtr_d    = shPtr_q;
    cmPtr_d    = cmPtr_q;
    pos_d      = pos_q;
    accept_d   = accept_q;
    seq_d      = seq_q;
    frameCnt_d = frameCnt_q;
    dropCnt_d  = dropCnt_q;

    if (take) begin
      if (frameStart) begin
        seq_d    = seq_q + 24'd1;
        accept_d = acceptNow;
      end
      pos_d = lastWord ? '0 : pos_q + POSW'(1);
      if (wrEn) begin
        shPtr_d = shPtr_q + PW'(1);
      end
      if (commit) begin
        cmPtr_d    = shPtr_q + PW'(1);
        frameCnt_d = frameCnt_q + 32'd1;
      end
    end

    if (resync && !commit) begin
      pos_d   = '0;
      shPtr_d = cmPtr_q;
    end

    if (dropEvt && (dropCnt_q != 16'hFFFF)) begin
      dropCnt_d = dropCnt_q + 16'd1;
    end

    if (clear_stats) begin
      frameCnt_d = '0;
      dropCnt_d  = '0;
    end
  end

  always_ff @(posedge dev_clk) begin
    if (wrEn) begin
      mem[shPtr_q[FIFO_AW-1:0]] <= {seq_q, data_in};
    end
  end

  // The read port follows the next read pointer so the word loaded after a pop
  // already comes from the following entry.
  assign handshake = tvalid_q && m_axis_tready;
  assign popNow    = handshake && (state_q == DATA) && (beat_q == 2'd2);
  assign rdPtr_d   = rdPtr_q + PW'(popNow);
  assign curEntry  = mem[rdPtr_d[FIFO_AW-1:0]];
  assign launch    = (state_q == IDLE) && (framesAvail_q != '0);

  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    entry_d       = entry_q;
    tdata_d       = tdata_q;
    tvalid_d      = tvalid_q;
    tlast_d       = tlast_q;
    framesAvail_d = framesAvail_q + PW'(commit) - PW'(launch);

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d  = HDR;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          tdata_d  = {8'hDD, curEntry[119:96]};
        end
      end
      HDR: begin
        if (handshake) begin
          state_d = DATA;
          beat_d  = 2'd0;
          entry_d = '0;
          tdata_d = curEntry[31:0];
          tlast_d = 1'b0;
        end
      end
      DATA: begin
        if (handshake) begin
          if (beat_q == 2'd2) begin
            if (entry_q == POSW'(N_CH - 1)) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tdata_d  = '0;
            end else begin
              entry_d = entry_q + POSW'(1);
              beat_d  = 2'd0;
              tdata_d = curEntry[31:0];
              tlast_d = 1'b0;
            end
          end else begin
            beat_d  = beat_q + 2'd1;
            tdata_d = (beat_q == 2'd0) ? curEntry[63:32] : curEntry[95:64];
            tlast_d = (beat_q == 2'd1) && (entry_q == POSW'(N_CH - 1));
          end
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tdata_d  = '0;
      end
    endcase
  end

  always_ff @(posedge dev_clk or posedge dev_rst) begin
    if (dev_rst) begin
      shPtr_q       <= '0;
      cmPtr_q       <= '0;
      rdPtr_q       <= '0;
      framesAvail_q <= '0;
      pos_q         <= '0;
      accept_q      <= 1'b0;
      seq_q         <= '0;
      frameCnt_q    <= '0;
      dropCnt_q     <= '0;
      state_q       <= IDLE;
      beat_q        <= '0;
      entry_q       <= '0;
      tdata_q       <= '0;
      tvalid_q      <= 1'b0;
      tlast_q       <= 1'b0;
    end else begin
      shPtr_q       <= shPtr_d;
      cmPtr_q       <= cmPtr_d;
      rdPtr_q       <= rdPtr_d;
      framesAvail_q <= framesAvail_d;
      pos_q         <= pos_d;
      accept_q      <= accept_d;
      seq_q         <= seq_d;
      frameCnt_q    <= frameCnt_d;
      dropCnt_q     <= dropCnt_d;
      state_q       <= state_d;
      beat_q        <= beat_d;
      entry_q       <= entry_d;
      tdata_q       <= tdata_d;
      tvalid_q      <= tvalid_d;
      tlast_q       <= tlast_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign frame_count   = frameCnt_q;
  assign drop_count    = dropCnt_q;

endmodule
